// File: rtl/pulse_train_ctrl.sv
// pulse_train_ctrl: turns a trigger rising edge into a programmed pulse train
// with busy/done/err status and synchronous abort.
module pulse_train_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inp_trig,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_count,
   output logic             out_pulse,
   output logic             busy,
   output logic             done,
   output logic             err
);
   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
   state_t           r_state, w_next;
   logic [1:0]       r_trig_d;
   logic [CNT_W-1:0] r_phase, r_pulses, r_w, r_l, r_c;
   logic             w_rise, w_start, w_rej, w_ph_end, w_more;
   logic             w_out, w_busy, w_done;
   assign w_rise   = r_trig_d[0] & ~r_trig_d[1];
   assign w_start  = (r_state == IDLE) & w_rise & (cfg_count != '0) & (cfg_width != '0);
   assign w_rej    = (r_state == IDLE) & w_rise & ((cfg_count == '0) | (cfg_width == '0));
   assign w_ph_end = r_phase == CNT_W'(1);
   assign w_more   = r_pulses < r_c;
   // trig_d resets to 11 so a trigger already high at reset release is not an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_trig_d  <= 2'b11;
         out_pulse <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_trig_d  <= {r_trig_d[0], inp_trig};
         out_pulse <= w_out;
         busy      <= w_busy;
         done      <= w_done;
         err       <= w_rej;
      end
   end
   always_comb begin
      w_next = (r_state == IDLE) ? (w_start ? HIGH : IDLE) :
               abort             ? IDLE :
               !w_ph_end         ? r_state :
               (r_state == HIGH) ? LOW :
               w_more            ? HIGH : IDLE;
   end
   always_comb begin
      w_out  = w_next == HIGH;
      w_busy = w_next != IDLE;
      w_done = (r_state == LOW) & ~abort & w_ph_end & ~w_more;
   end
   // phase counter counts down to 1; pulse counter counts pulses started so far
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase  <= '0;
         r_pulses <= '0;
         r_w      <= '0;
         r_l      <= '0;
         r_c      <= '0;
      end else if (w_start) begin
         r_w      <= cfg_width;
         r_c      <= cfg_count;
         r_l      <= (cfg_period > cfg_width) ? cfg_period - cfg_width : CNT_W'(1);
         r_phase  <= cfg_width;
         r_pulses <= CNT_W'(1);
      end else if (r_state != IDLE && !abort) begin
         if (w_ph_end) begin
            r_phase <= (r_state == HIGH) ? r_l : r_w;
            if (r_state == LOW && w_more) r_pulses <= r_pulses + CNT_W'(1);
         end else begin
            r_phase <= r_phase - CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_pulse_train_ctrl.sv
// tb_pulse_train_ctrl: directed table-driven checks of pulse_train_ctrl.
module tb_pulse_train_ctrl;
   logic        clk = 1'b0;
   logic        rst, inp_trig, abort;
   logic [15:0] cfg_width, cfg_period, cfg_count;
   logic        out_pulse, busy, done, err;
   int          checks = 0;
   int          fails = 0;
   typedef struct {
      int w;
      int p;
      int c;
      int l;
      int busy_len;
      bit disturb;
   } vec_t;
   vec_t vecs[5];
   pulse_train_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .inp_trig(inp_trig), .abort(abort),
      .cfg_width(cfg_width), .cfg_period(cfg_period), .cfg_count(cfg_count),
      .out_pulse(out_pulse), .busy(busy), .done(done), .err(err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%0b exp=%0b t=%0t", name, act, exp, $time);
      end
   endtask
   task automatic run(input vec_t v);
      cfg_width  = 16'(v.w);
      cfg_period = 16'(v.p);
      cfg_count  = 16'(v.c);
      inp_trig   = 1'b0;
      @(negedge clk);
      inp_trig = 1'b1;
      @(negedge clk);
      chk("latency_busy", busy, 1'b0);
      chk("latency_out", out_pulse, 1'b0);
      inp_trig = 1'b0;
      for (int i = 0; i < v.busy_len; i++) begin
         if (v.disturb && i == 6) begin
            inp_trig   = 1'b1;
            cfg_width  = 16'd7;
            cfg_period = 16'd20;
            cfg_count  = 16'd1;
         end
         if (v.disturb && i == 12) inp_trig = 1'b0;
         @(negedge clk);
         chk("pulse", out_pulse, (i % (v.w + v.l)) < v.w);
         chk("busy", busy, 1'b1);
         chk("done_early", done, 1'b0);
         chk("err_in_run", err, 1'b0);
      end
      @(negedge clk);
      chk("done_strobe", done, 1'b1);
      chk("busy_end", busy, 1'b0);
      chk("out_end", out_pulse, 1'b0);
      @(negedge clk);
      chk("done_fall", done, 1'b0);
   endtask
   task automatic reject(input int w, input int c);
      cfg_width  = 16'(w);
      cfg_count  = 16'(c);
      cfg_period = 16'd8;
      inp_trig   = 1'b0;
      @(negedge clk);
      inp_trig = 1'b1;
      @(negedge clk);
      chk("err_early", err, 1'b0);
      @(negedge clk);
      chk("err_strobe", err, 1'b1);
      chk("rej_busy", busy, 1'b0);
      chk("rej_out", out_pulse, 1'b0);
      inp_trig = 1'b0;
      @(negedge clk);
      chk("err_fall", err, 1'b0);
      chk("rej_busy2", busy, 1'b0);
   endtask
   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("quiet_busy", busy, 1'b0);
         chk("quiet_out", out_pulse, 1'b0);
         chk("quiet_done", done, 1'b0);
         chk("quiet_err", err, 1'b0);
      end
   endtask
   task automatic start(input int w, input int p, input int c);
      cfg_width  = 16'(w);
      cfg_period = 16'(p);
      cfg_count  = 16'(c);
      inp_trig   = 1'b0;
      @(negedge clk);
      inp_trig = 1'b1;
   endtask
   initial begin
      vecs[0] = '{w: 3, p: 8,  c: 4, l: 5, busy_len: 32, disturb: 1'b0};
      vecs[1] = '{w: 5, p: 5,  c: 2, l: 1, busy_len: 12, disturb: 1'b0};
      vecs[2] = '{w: 6, p: 4,  c: 2, l: 1, busy_len: 14, disturb: 1'b0};
      vecs[3] = '{w: 2, p: 10, c: 5, l: 8, busy_len: 50, disturb: 1'b1};
      vecs[4] = '{w: 1, p: 1,  c: 1, l: 1, busy_len: 2,  disturb: 1'b0};
      rst = 1'b1; inp_trig = 1'b0; abort = 1'b0;
      cfg_width = '0; cfg_period = '0; cfg_count = '0;
      repeat (2) @(negedge clk);
      chk("rst_out", out_pulse, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 5; k++) run(vecs[k]);
      reject(3, 0);
      run(vecs[4]);
      reject(0, 2);
      run(vecs[1]);
      // abort in the second cycle of pulse 2 (W=4, L=2)
      start(4, 6, 3);
      repeat (9) @(negedge clk);
      chk("pre_abort_out", out_pulse, 1'b1);
      abort = 1'b1;
      inp_trig = 1'b0;
      @(negedge clk);
      chk("abort_out", out_pulse, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_err", err, 1'b0);
      abort = 1'b0;
      quiet(25);
      start(4, 6, 3);
      repeat (3) @(negedge clk);
      chk("pre_rst_out", out_pulse, 1'b1);
      rst = 1'b1;
      inp_trig = 1'b0;
      @(negedge clk);
      chk("midrst_out", out_pulse, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_err", err, 1'b0);
      rst = 1'b0;
      quiet(25);
      rst = 1'b1;
      inp_trig = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      quiet(6);
      run(vecs[0]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
